// File: rtl/hazard_if.sv
// hazard_if: bundles the pipeline-side signals of the hazard controller.
//   Decode side : rs_fd, rt_fd, uses_rs_fd, uses_rt_fd, branch_taken_fd, hlt_fd
//   Execute side: mem_read_de, write_reg_de
//   Memory side : imem_stall, dmem_req_xm, dmem_ready
//   Controls    : pc_en, fd_en, de_en, xm_en, mw_en, fd_flush, de_flush, mw_flush
//   Status      : halted, stall_cycles
// The slave modport belongs to the controller. The master modport belongs to the
// pipeline (or a testbench), which drives the observations and consumes the controls.
interface hazard_if;
    logic [3:0]  rs_fd;
    logic [3:0]  rt_fd;
    logic        uses_rs_fd;
    logic        uses_rt_fd;
    logic        mem_read_de;
    logic [3:0]  write_reg_de;
    logic        branch_taken_fd;
    logic        hlt_fd;
    logic        imem_stall;
    logic        dmem_req_xm;
    logic        dmem_ready;
    logic        pc_en;
    logic        fd_en;
    logic        de_en;
    logic        xm_en;
    logic        mw_en;
    logic        fd_flush;
    logic        de_flush;
    logic        mw_flush;
    logic        halted;
    logic [15:0] stall_cycles;

    modport master (
        output rs_fd, rt_fd, uses_rs_fd, uses_rt_fd, mem_read_de, write_reg_de,
               branch_taken_fd, hlt_fd, imem_stall, dmem_req_xm, dmem_ready,
        input  pc_en, fd_en, de_en, xm_en, mw_en, fd_flush, de_flush, mw_flush,
               halted, stall_cycles
    );

    modport slave (
        input  rs_fd, rt_fd, uses_rs_fd, uses_rt_fd, mem_read_de, write_reg_de,
               branch_taken_fd, hlt_fd, imem_stall, dmem_req_xm, dmem_ready,
        output pc_en, fd_en, de_en, xm_en, mw_en, fd_flush, de_flush, mw_flush,
               halted, stall_cycles
    );
endinterface

// File: rtl/hazard_controller.sv
// hazard_controller: stall/flush sequencer for the five-stage pipeline.
// Ports:
//   clk : core clock, rising edge
//   rst : synchronous active-high reset
//   hz  : hazard_if.slave -- hazard observations in, PC/pipeline register
//         enables and flushes out, plus halted status and a saturating
//         16-bit stall-cycle counter.
// Controls are combinational from the state plus the current inputs.
// Priority: data-memory stall > load-use > branch/imem handling.
module hazard_controller (
    input  logic     clk,
    input  logic     rst,
    hazard_if.slave  hz
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        DRAIN    = 2'd2,
        HALTED   = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic        ret_drain_q, ret_drain_d;   // MEM_WAIT returns to DRAIN when set
    logic [1:0]  drain_cnt_q, drain_cnt_d;
    logic [15:0] stall_q, stall_d;

    logic dstall;
    logic lu;
    logic do_freeze, do_run, do_drain;
    logic pc_en_c, fd_en_c, de_en_c, xm_en_c, mw_en_c;
    logic fd_flush_c, de_flush_c, mw_flush_c, halted_c;

    // Register 0 is hardwired, so a load targeting it never creates a hazard.
    always_comb begin
        lu = hz.mem_read_de && (hz.write_reg_de != 4'd0) &&
             ((hz.uses_rs_fd && (hz.rs_fd == hz.write_reg_de)) ||
              (hz.uses_rt_fd && (hz.rt_fd == hz.write_reg_de)));
    end

    // Inside MEM_WAIT the request is already known outstanding, so only
    // dmem_ready matters there.
    always_comb begin
        dstall = 1'b0;
        case (state_q)
            RUN, DRAIN: dstall = hz.dmem_req_xm && !hz.dmem_ready;
            MEM_WAIT:   dstall = !hz.dmem_ready;
            default:    dstall = 1'b0;
        endcase
    end

    // Decide which behaviour this cycle follows. A MEM_WAIT release cycle
    // behaves like a non-stalled cycle of the state it returns to.
    always_comb begin
        do_freeze = 1'b0;
        do_run    = 1'b0;
        do_drain  = 1'b0;
        case (state_q)
            RUN: begin
                do_freeze = dstall;
                do_run    = !dstall;
            end
            MEM_WAIT: begin
                do_freeze = dstall;
                do_run    = !dstall && !ret_drain_q;
                do_drain  = !dstall && ret_drain_q;
            end
            DRAIN: begin
                do_freeze = dstall;
                do_drain  = !dstall;
            end
            default: ;
        endcase
    end

    always_comb begin
        pc_en_c     = 1'b0;
        fd_en_c     = 1'b0;
        de_en_c     = 1'b0;
        xm_en_c     = 1'b0;
        mw_en_c     = 1'b0;
        fd_flush_c  = 1'b0;
        de_flush_c  = 1'b0;
        mw_flush_c  = 1'b0;
        halted_c    = 1'b0;
        state_d     = state_q;
        ret_drain_d = ret_drain_q;
        drain_cnt_d = drain_cnt_q;

        if (do_freeze) begin
            // Freeze the front of the pipe; MEM/WB keeps moving but takes a
            // bubble so the stalled memory instruction is not retired twice.
            mw_en_c    = 1'b1;
            mw_flush_c = 1'b1;
            state_d    = MEM_WAIT;
            if (state_q != MEM_WAIT) begin
                ret_drain_d = (state_q == DRAIN);
            end
        end else if (do_run) begin
            state_d = RUN;
            if (lu) begin
                // One bubble into ID/EX; branch and HLT are re-seen next cycle.
                de_en_c    = 1'b1;
                de_flush_c = 1'b1;
                xm_en_c    = 1'b1;
                mw_en_c    = 1'b1;
            end else begin
                fd_en_c    = 1'b1;
                de_en_c    = 1'b1;
                xm_en_c    = 1'b1;
                mw_en_c    = 1'b1;
                fd_flush_c = hz.branch_taken_fd || hz.imem_stall;
                // A taken branch always loads its target, even without a
                // valid fetch word this cycle.
                pc_en_c    = !(hz.imem_stall && !hz.branch_taken_fd);
                if (hz.hlt_fd) begin
                    state_d     = DRAIN;
                    drain_cnt_d = 2'd3;
                end
            end
        end else if (do_drain) begin
            // Fetch is shut off; the older instructions keep flowing out.
            fd_en_c    = 1'b1;
            de_en_c    = 1'b1;
            xm_en_c    = 1'b1;
            mw_en_c    = 1'b1;
            fd_flush_c = 1'b1;
            if (drain_cnt_q <= 2'd1) begin
                drain_cnt_d = 2'd0;
                state_d     = HALTED;
            end else begin
                drain_cnt_d = drain_cnt_q - 2'd1;
                state_d     = DRAIN;
            end
        end else if (state_q == HALTED) begin
            halted_c = 1'b1;
        end

        // Reset forces every control quiet regardless of state.
        if (rst) begin
            pc_en_c    = 1'b0;
            fd_en_c    = 1'b0;
            de_en_c    = 1'b0;
            xm_en_c    = 1'b0;
            mw_en_c    = 1'b0;
            fd_flush_c = 1'b0;
            de_flush_c = 1'b0;
            mw_flush_c = 1'b0;
            halted_c   = 1'b0;
        end
    end

    // Only RUN and MEM_WAIT stalls are charged; draining and halted are not.
    always_comb begin
        stall_d = stall_q;
        if (!pc_en_c && ((state_q == RUN) || (state_q == MEM_WAIT)) &&
            (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            ret_drain_q <= 1'b0;
            drain_cnt_q <= 2'd0;
            stall_q     <= 16'd0;
        end else begin
            state_q     <= state_d;
            ret_drain_q <= ret_drain_d;
            drain_cnt_q <= drain_cnt_d;
            stall_q     <= stall_d;
        end
    end

    assign hz.pc_en        = pc_en_c;
    assign hz.fd_en        = fd_en_c;
    assign hz.de_en        = de_en_c;
    assign hz.xm_en        = xm_en_c;
    assign hz.mw_en        = mw_en_c;
    assign hz.fd_flush     = fd_flush_c;
    assign hz.de_flush     = de_flush_c;
    assign hz.mw_flush     = mw_flush_c;
    assign hz.halted       = halted_c;
    assign hz.stall_cycles = stall_q;

endmodule

// File: doc/hazard_controller.md
# hazard_controller

Central stall/flush sequencer for the five-stage pipeline. Watches the decode, execute and memory stages, and drives the write-enable and flush controls of the PC and the four pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB). It resolves load-use hazards, taken-branch squashes, instruction- and data-memory wait states, and halt draining. It also keeps a saturating stall-cycle counter for performance measurement.

## Interface
- No parameters.
- `clk` in 1: core clock, all state updates on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `rs_fd`, `rt_fd` in 4 each: source register numbers of the instruction in IF/ID.
- `uses_rs_fd`, `uses_rt_fd` in 1 each: the decode instruction actually reads `rs_fd` / `rt_fd`.
- `mem_read_de` in 1: the instruction in ID/EX is a load.
- `write_reg_de` in 4: destination register of the ID/EX instruction.
- `branch_taken_fd` in 1: a branch resolved in decode is taken.
- `hlt_fd` in 1: the instruction in IF/ID is HLT.
- `imem_stall` in 1: instruction memory has no valid word this cycle.
- `dmem_req_xm` in 1: the EX/MEM instruction accesses data memory.
- `dmem_ready` in 1: data memory completes the outstanding access this cycle (pulse).
- `pc_en`, `fd_en`, `de_en`, `xm_en`, `mw_en` out 1 each: write enables for the PC and each pipeline register.
- `fd_flush`, `de_flush`, `mw_flush` out 1 each: load a bubble (all-zero controls) into IF/ID, ID/EX and MEM/WB respectively.
- `halted` out 1: the pipeline has drained after HLT.
- `stall_cycles` out 16: count of cycles with `pc_en`=0 while not in DRAIN/HALTED.

## Operation
- FSM states: RUN, MEM_WAIT, DRAIN, HALTED. Outputs are combinational from state plus current inputs.
- `dstall` = (`dmem_req_xm` & ~`dmem_ready`) in RUN/DRAIN, or ~`dmem_ready` in MEM_WAIT.
- `lu` (load-use) = `mem_read_de` & `write_reg_de`≠0 & ((`uses_rs_fd` & `rs_fd`==`write_reg_de`) | (`uses_rt_fd` & `rt_fd`==`write_reg_de`)). Register 0 never causes a hazard.
- Priority, highest first:
  1. `dstall`: pc/fd/de/xm enables 0; `mw_en`=1 with `mw_flush`=1; all other flushes 0.
  2. `lu`: `pc_en`=`fd_en`=0; `de_en`=1 with `de_flush`=1; `xm_en`=`mw_en`=1. `branch_taken_fd` and `hlt_fd` are ignored this cycle (re-evaluated next cycle).
  3. Otherwise all enables are 1. `fd_flush`=`branch_taken_fd` | `imem_stall`. `pc_en`=0 if `imem_stall` & ~`branch_taken_fd` (a taken branch always loads its target).
- Transitions:
  - RUN→MEM_WAIT on `dstall`.
  - MEM_WAIT→RUN (or back to DRAIN if entered from DRAIN) in the cycle `dmem_ready`=1; that cycle behaves as a non-`dstall` cycle. A one-bit flag remembers the return state.
  - RUN→DRAIN when `hlt_fd` & ~`dstall` & ~`lu`; the drain counter is loaded with 3.
  - DRAIN: `pc_en`=0 and `fd_flush`=1 every cycle; `branch_taken_fd`, `hlt_fd`, `imem_stall` and `lu` are ignored. The counter decrements on each cycle without `dstall`. DRAIN→MEM_WAIT on `dstall`. DRAIN→HALTED when the counter decrements from 1 to 0.
  - HALTED: all enables 0, all flushes 0, `halted`=1. Only `rst` exits.
- `stall_cycles` increments on cycles with `pc_en`=0 in RUN or MEM_WAIT, and saturates at 0xFFFF (no wrap).

## Timing
- While `rst`=1: all enables 0, flushes 0, `halted`=0. On the next edge: state RUN, drain counter 0, `stall_cycles`=0.
- Reset asserted in any state, including mid-MEM_WAIT or mid-DRAIN, returns to RUN in one cycle with no residual stall.
- Load-use costs exactly one bubble: `pc_en` is low for one cycle, then the stalled instruction proceeds.
- `dstall` with `dmem_ready` arriving N cycles after the request gives N cycles of freeze. A same-cycle `dmem_ready` gives zero stall.
- `halted` rises 3 non-`dstall` cycles after the cycle HLT was accepted in decode.

## Test plan
- Load-use: `mem_read_de`=1, `write_reg_de`=5, `rs_fd`=5, `uses_rs_fd`=1 -> `pc_en`=`fd_en`=0 and `de_flush`=1 for 1 cycle; `stall_cycles`=1. Repeat with `write_reg_de`=0 -> no stall.
- Taken branch with `imem_stall`=1 in the same cycle -> `pc_en`=1, `fd_flush`=1. `imem_stall` alone -> `pc_en`=0, `fd_flush`=1.
- Data-memory wait: `dmem_req_xm`=1, `dmem_ready` pulsing 4 cycles later -> 4 cycles of pc/fd/de/xm enables 0 with `mw_flush`=1, then all enables 1; `stall_cycles`=4.
- Halt: `hlt_fd`=1 in RUN -> DRAIN, `pc_en`=0, `halted`=1 on the 4th edge after acceptance. With a 2-cycle `dstall` during DRAIN -> `halted` is delayed by 2 cycles.
- Load-use coincident with `branch_taken_fd`, and with `hlt_fd` -> stall only, no `fd_flush`, no DRAIN entry that cycle.
- `rst` pulsed in HALTED and in MEM_WAIT -> next cycle RUN, all enables 1, `halted`=0, `stall_cycles`=0. Force 70000 stall cycles -> `stall_cycles` holds at 0xFFFF.
